// File: rtl/integer_vector_dot_stream.sv
// Streaming integer dot product. Each beat carries MULTS element pairs, and each
// element pair goes to its own lane. Each lane multiplies its pair and keeps a running
// sum. The beat that completes a vector folds the lane sums into the reduce
// register. The reduce register then feeds a range-checked output register that
// uses valid/ready handshaking.
module integer_vector_dot_stream #(
   parameter int BITS     = 16,
   parameter int LENGTH   = 10,
   parameter int MULTS    = 2,
   parameter int ACC_BITS = 2*BITS + $clog2(LENGTH),
   parameter int SIGNED   = 1,
   parameter int SATURATE = 1
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [MULTS-1:0][BITS-1:0]  vector_a,
   input  logic [MULTS-1:0][BITS-1:0]  vector_b,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [BITS-1:0]             c,
   output logic                        c_overflow
);

   localparam int BEATS = LENGTH / MULTS;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   // A vector must split into whole beats.
   if (LENGTH % MULTS != 0) begin : g_bad_length
      $error("integer_vector_dot_stream: LENGTH must be a multiple of MULTS");
   end

   logic [CNT_W-1:0]                beat_reg;
   logic [MULTS-1:0][ACC_BITS-1:0]  lane_sum;
   logic [ACC_BITS-1:0]             red_next;
   logic [ACC_BITS-1:0]             red_reg;
   logic                            r_v_reg;
   logic                            out_valid_reg;
   logic [BITS-1:0]                 c_reg;
   logic                            ovf_reg;
   logic [BITS-1:0]                 c_next;
   logic                            ovf_next;
   logic                            accept;
   logic                            last_accept;
   logic                            o_load;
   logic                            o_take;

   // Back-pressure applies only when both R and O are occupied and O is not draining.
   assign in_ready    = !(r_v_reg && out_valid_reg && !out_ready);
   assign accept      = in_valid && in_ready;
   assign last_accept = accept && (beat_reg == LAST_BEAT);
   assign o_take      = out_valid_reg && out_ready;
   assign o_load      = r_v_reg && (!out_valid_reg || out_ready);

   // Per-lane multiplier and accumulator.
   for (genvar gi = 0; gi < MULTS; gi++) begin : g_lane
      logic [2*BITS-1:0]   prod;
      logic [ACC_BITS-1:0] prod_ext;
      logic [ACC_BITS-1:0] acc;

      if (SIGNED != 0) begin : g_signed
         assign prod     = (2*BITS)'($signed(vector_a[gi])) * (2*BITS)'($signed(vector_b[gi]));
         assign prod_ext = ACC_BITS'($signed(prod));
      end else begin : g_unsigned
         assign prod     = (2*BITS)'(vector_a[gi]) * (2*BITS)'(vector_b[gi]);
         assign prod_ext = ACC_BITS'(prod);
      end

      // Beat 0 restarts the sum, so no separate clear is needed between vectors.
      assign lane_sum[gi] = (beat_reg == '0) ? prod_ext : acc + prod_ext;

      // Lane accumulator advances on every accepted beat.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn)       acc <= '0;
         else if (accept) acc <= lane_sum[gi];
      end
   end

   // Cross-lane reduction of the sums that include the current beat.
   always_comb begin
      red_next = '0;
      for (int i = 0; i < MULTS; i++) red_next = red_next + lane_sum[i];
   end

   // Range check: the sum fits BITS when every bit above the result field matches its sign (or is zero when unsigned).
   if (SIGNED != 0) begin : g_range_s
      logic [ACC_BITS-BITS:0] hi_bits;
      logic [BITS-1:0]        sat_val;
      assign hi_bits  = red_reg[ACC_BITS-1:BITS-1];
      assign ovf_next = !((&hi_bits) || !(|hi_bits));
      assign sat_val  = red_reg[ACC_BITS-1] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
      assign c_next   = (ovf_next && SATURATE != 0) ? sat_val : red_reg[BITS-1:0];
   end else begin : g_range_u
      assign ovf_next = |red_reg[ACC_BITS-1:BITS];
      assign c_next   = (ovf_next && SATURATE != 0) ? {BITS{1'b1}} : red_reg[BITS-1:0];
   end

   // The beat counter wraps after the last beat of each vector.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)            beat_reg <= '0;
      else if (last_accept) beat_reg <= '0;
      else if (accept)      beat_reg <= beat_reg + 1'b1;
   end

   // Reduce register R: a new last beat refills it even while its old content moves to O.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         red_reg <= '0;
         r_v_reg <= 1'b0;
      end else if (last_accept) begin
         red_reg <= red_next;
         r_v_reg <= 1'b1;
      end else if (o_load) begin
         r_v_reg <= 1'b0;
      end
   end

   // Output register O: it loads from R when free or draining, and it holds steady while stalled.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid_reg <= 1'b0;
         c_reg         <= '0;
         ovf_reg       <= 1'b0;
      end else if (o_load) begin
         out_valid_reg <= 1'b1;
         c_reg         <= c_next;
         ovf_reg       <= ovf_next;
      end else if (o_take) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid  = out_valid_reg;
   assign c          = out_valid_reg ? c_reg : '0;
   assign c_overflow = out_valid_reg & ovf_reg;

endmodule

// File: tb/tb_integer_vector_dot_stream.sv
// Directed bench for integer_vector_dot_stream. It uses BITS=16, LENGTH=4 and MULTS=2.
// Three instances share one stimulus: the signed saturating instance is the main
// one, and the other two are an unsigned instance and a truncating instance.
module tb_integer_vector_dot_stream;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 in_valid;
   logic [1:0][15:0]     vector_a;
   logic [1:0][15:0]     vector_b;
   logic                 out_ready;
   logic                 in_ready, in_ready_u, in_ready_t;
   logic                 out_valid, out_valid_u, out_valid_t;
   logic [15:0]          c, c_u, c_t;
   logic                 c_overflow, c_overflow_u, c_overflow_t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic chk_ready = 1'b0;

   typedef struct {
      logic [15:0] c;  logic ov;
      logic [15:0] cu; logic ovu;
      logic [15:0] ct; logic ovt;
      int          cyc;
   } res_t;
   res_t res_q[$];

   typedef struct {
      logic [3:0][15:0] a;
      logic [3:0][15:0] b;
      int               sel;     // 0 signed/saturate, 1 unsigned, 2 truncate
      logic [15:0]      exp_c;
      logic             exp_ov;
   } vec_t;
   vec_t tbl[12];

   always #5 clk = ~clk;

   integer_vector_dot_stream #(.BITS(16), .LENGTH(4), .MULTS(2), .SIGNED(1), .SATURATE(1)) u_main (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .vector_a(vector_a), .vector_b(vector_b), .out_valid(out_valid),
      .out_ready(out_ready), .c(c), .c_overflow(c_overflow));

   integer_vector_dot_stream #(.BITS(16), .LENGTH(4), .MULTS(2), .SIGNED(0), .SATURATE(1)) u_uns (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_u),
      .vector_a(vector_a), .vector_b(vector_b), .out_valid(out_valid_u),
      .out_ready(out_ready), .c(c_u), .c_overflow(c_overflow_u));

   integer_vector_dot_stream #(.BITS(16), .LENGTH(4), .MULTS(2), .SIGNED(1), .SATURATE(0)) u_trunc (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_t),
      .vector_a(vector_a), .vector_b(vector_b), .out_valid(out_valid_t),
      .out_ready(out_ready), .c(c_t), .c_overflow(c_overflow_t));

   // Cycle counter used to measure result spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Result monitor: it records a handshake in mid-cycle, before the edge that consumes it.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         res_t r;
         r.c = c; r.ov = c_overflow; r.cu = c_u; r.ovu = c_overflow_u;
         r.ct = c_t; r.ovt = c_overflow_t; r.cyc = cyc;
         res_q.push_back(r);
      end
      if (chk_ready) begin
         total++;
         if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL in_ready_sustained: got %b expected 1 at cycle %0d", in_ready, cyc);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end else begin
         $display("ok   %s = 0x%0h", nm, act);
      end
   endtask

   // Offer one vector as two beats; each beat is held until the bench sees in_ready before an edge.
   task automatic send_vec(input logic [3:0][15:0] a, input logic [3:0][15:0] b);
      for (int bt = 0; bt < 2; bt++) begin
         int   waited = 0;
         logic ok = 1'b0;
         in_valid    = 1'b1;
         vector_a[0] = a[2*bt];
         vector_a[1] = a[2*bt+1];
         vector_b[0] = b[2*bt];
         vector_b[1] = b[2*bt+1];
         do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            waited++;
         end while (!ok && waited < 40);
         if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", waited);
         end
      end
   endtask

   task automatic wait_results(input int n);
      int w = 0;
      while (res_q.size() < n && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      logic [15:0] a0;
      tbl[0]  = '{a:{16'd4, 16'd3, 16'd2, 16'd1}, b:{16'd8, 16'd7, 16'd6, 16'd5}, sel:0, exp_c:16'h0046, exp_ov:1'b0};
      tbl[1]  = '{a:{4{16'hFFFD}}, b:{4{16'd2}}, sel:0, exp_c:16'hFFE8, exp_ov:1'b0};
      tbl[2]  = '{a:{4{16'hFFFF}}, b:{4{16'hFFFF}}, sel:1, exp_c:16'hFFFF, exp_ov:1'b1};
      tbl[3]  = '{a:{4{16'h7FFF}}, b:{4{16'h7FFF}}, sel:0, exp_c:16'h7FFF, exp_ov:1'b1};
      tbl[4]  = '{a:{4{16'h8000}}, b:{4{16'h7FFF}}, sel:0, exp_c:16'h8000, exp_ov:1'b1};
      tbl[5]  = '{a:{4{16'h7FFF}}, b:{4{16'h7FFF}}, sel:2, exp_c:16'h0004, exp_ov:1'b1};
      tbl[6]  = '{a:{16'd0, 16'd0, 16'd0, 16'h7FFF}, b:{16'd0, 16'd0, 16'd0, 16'd1}, sel:0, exp_c:16'h7FFF, exp_ov:1'b0};
      tbl[7]  = '{a:{16'd0, 16'd0, 16'd0, 16'h8000}, b:{16'd0, 16'd0, 16'd0, 16'd1}, sel:0, exp_c:16'h8000, exp_ov:1'b0};
      tbl[8]  = '{a:{16'd0, 16'd0, 16'd1, 16'h7FFF}, b:{16'd0, 16'd0, 16'd1, 16'd1}, sel:0, exp_c:16'h7FFF, exp_ov:1'b1};
      tbl[9]  = '{a:{16'd0, 16'd0, 16'd0, 16'hFFFF}, b:{16'd0, 16'd0, 16'd0, 16'd1}, sel:1, exp_c:16'hFFFF, exp_ov:1'b0};
      tbl[10] = '{a:{16'd0, 16'd7, 16'hFFCE, 16'd100}, b:{16'd9, 16'hFFFE, 16'd4, 16'd3}, sel:2, exp_c:16'h0056, exp_ov:1'b0};
      tbl[11] = '{a:{4{16'hFFFF}}, b:{4{16'hFFFF}}, sel:0, exp_c:16'h0004, exp_ov:1'b0};

      rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      vector_a = '0; vector_b = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_c", {16'd0, c}, 32'd0);
      chk("reset_c_overflow", {31'd0, c_overflow}, 32'd0);
      rstn = 1'b1;
      #1;
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

      // Latency: R loads on the last-beat edge and O loads on the edge after it.
      send_vec(tbl[0].a, tbl[0].b);
      in_valid = 1'b0;
      chk("lat_not_yet_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_c", {16'd0, c}, 32'h46);
      chk("lat_c_overflow", {31'd0, c_overflow}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      res_q.delete();

      // Table vectors, sent back to back.
      foreach (tbl[i]) send_vec(tbl[i].a, tbl[i].b);
      in_valid = 1'b0;
      wait_results(12);
      chk("table_count", res_q.size(), 32'd12);
      n = (res_q.size() < 12) ? res_q.size() : 12;
      for (int i = 0; i < n; i++) begin
         case (tbl[i].sel)
            1: begin
               chk($sformatf("vec%0d_c_unsigned", i), {16'd0, res_q[i].cu}, {16'd0, tbl[i].exp_c});
               chk($sformatf("vec%0d_ov_unsigned", i), {31'd0, res_q[i].ovu}, {31'd0, tbl[i].exp_ov});
            end
            2: begin
               chk($sformatf("vec%0d_c_trunc", i), {16'd0, res_q[i].ct}, {16'd0, tbl[i].exp_c});
               chk($sformatf("vec%0d_ov_trunc", i), {31'd0, res_q[i].ovt}, {31'd0, tbl[i].exp_ov});
            end
            default: begin
               chk($sformatf("vec%0d_c", i), {16'd0, res_q[i].c}, {16'd0, tbl[i].exp_c});
               chk($sformatf("vec%0d_ov", i), {31'd0, res_q[i].ov}, {31'd0, tbl[i].exp_ov});
            end
         endcase
      end
      res_q.delete();

      // Back-pressure: the first vector waits in O, the second waits in R, and the third is stalled.
      out_ready = 1'b0;
      send_vec(tbl[0].a, tbl[0].b);
      send_vec(tbl[1].a, tbl[1].b);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_c_first", {16'd0, c}, 32'h46);
      fork
         send_vec(tbl[11].a, tbl[11].b);
         begin
            for (int k = 0; k < 3; k++) begin
               @(posedge clk);
               #1;
               chk($sformatf("bp_c_hold%0d", k), {16'd0, c}, 32'h46);
            end
            out_ready = 1'b1;
         end
      join
      in_valid = 1'b0;
      wait_results(3);
      chk("bp_count", res_q.size(), 32'd3);
      if (res_q.size() >= 3) begin
         chk("bp_res0", {16'd0, res_q[0].c}, 32'h0046);
         chk("bp_res1", {16'd0, res_q[1].c}, 32'hFFE8);
         chk("bp_res2", {16'd0, res_q[2].c}, 32'h0004);
      end
      repeat (4) @(posedge clk);
      #1;
      chk("bp_no_extra", res_q.size(), 32'd3);
      res_q.delete();

      // Asynchronous reset with a result held in O and a partial vector in progress.
      out_ready = 1'b0;
      send_vec(tbl[0].a, tbl[0].b);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pre_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b1;
      vector_a = {16'd9, 16'd9};
      vector_b = {16'd9, 16'd9};
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_async_c", {16'd0, c}, 32'd0);
      chk("rst_async_ov", {31'd0, c_overflow}, 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      out_ready = 1'b1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      res_q.delete();
      send_vec(tbl[0].a, tbl[0].b);
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("rst_new_count", res_q.size(), 32'd1);
      if (res_q.size() >= 1) chk("rst_new_c", {16'd0, res_q[0].c}, 32'h0046);
      res_q.delete();

      // Sustained stream: eight vectors, with the expected dot product a0*1 + 1*a0 + 2 + 3.
      chk_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         a0 = 16'(k + 1);
         send_vec({16'd3, 16'd2, 16'd1, a0}, {16'd1, 16'd1, a0, 16'd1});
      end
      chk_ready = 1'b0;
      in_valid = 1'b0;
      wait_results(8);
      chk("stream_count", res_q.size(), 32'd8);
      n = (res_q.size() < 8) ? res_q.size() : 8;
      for (int k = 0; k < n; k++) begin
         chk($sformatf("stream%0d_c", k), {16'd0, res_q[k].c}, 32'(2 * (k + 1) + 5));
         if (k > 0) chk($sformatf("stream%0d_gap", k), 32'(res_q[k].cyc - res_q[k-1].cyc), 32'd2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
